adder_mul_sequencer: RTL and testbench
======================================

Name: adder_mul_sequencer

Overview:
- Controller that owns one WIDTH-bit ripple adder and schedules it for two operations: a single-pass add, or a WIDTH-iteration shift-add multiply.
- Sits between the user-IO decode logic (operand capture) and the output pin mux.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- WIDTH, 4, operand width in bits; result width is 2*WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  requester presents an operation
- in_ready  output  1  sequencer can accept an operation
- in_op  input  1  0 = add, 1 = multiply
- in_a  input  WIDTH  operand A (multiplicand for multiply)
- in_b  input  WIDTH  operand B (multiplier for multiply)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_result  output  2*WIDTH  result
- out_op  output  1  op code of the returned result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst). rst has priority over every other input.
- Reset values: state=IDLE, out_valid=0, out_result=0, out_op=0, busy=0, step counter=0, internal hi/lo/a registers=0. in_ready=1 from the first cycle after reset.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_op, in_a, in_b; set hi=0, lo=in_b, cnt=0; go to EXEC.
- EXEC, add (op=0), exactly one cycle:
  - {cout,sum} = a + lo via the adder.
  - out_result <= zero-extended {cout,sum}.
  - Go to DONE.
- EXEC, multiply (op=1), exactly WIDTH cycles:
  - If lo[0]=1: {c,s} = hi + a. Else: {c,s} = {0,hi}.
  - {hi,lo} <= {c, s, lo[WIDTH-1:1]}; cnt <= cnt+1.
  - When cnt reaches WIDTH-1: register the final {hi,lo} into out_result and go to DONE.
- DONE:
  - out_valid=1; out_result and out_op are held stable.
  - On out_ready: go to IDLE and deassert out_valid.
- Latency, with the accept edge at cycle T:
  - add: out_valid first high at T+2.
  - multiply: out_valid first high at T+WIDTH+1 (T+5 for WIDTH=4).
- Handshake:
  - in_ready is 0 in EXEC and DONE. in_valid is ignored there and operands are not sampled.
  - No same-cycle accept on the DONE→IDLE transition: minimum issue interval is latency+1.
  - out_valid never drops without out_ready.
- Arithmetic:
  - Unsigned only.
  - Add carry lands in bit WIDTH; upper bits are 0.
  - Multiply result is the full 2*WIDTH product, never truncated.
- Boundary conditions:
  - Operands of 0 or all-ones need no special-casing.
  - The multiply step counter does not wrap within an operation and is cleared on accept.
- Reset mid-operation: in EXEC or DONE, rst returns to IDLE next edge, drops out_valid, clears out_result; the partial result is discarded.
- busy = (state != IDLE).

Decomposition:
- Shared package:
  - state enum {IDLE, EXEC, DONE}.
  - op constants OP_ADD=1'b0, OP_MUL=1'b1.
  - Counter width function clog2(WIDTH).
- One sub-module: ripple_adder_w, a WIDTH-bit combinational ripple adder with carry-out, instanced once. All add traffic goes through it.

Test Plan:
- Add 9+8, out_ready=1: accept at T → out_valid at T+2, out_result=8'h11, out_op=0; in_ready low in T+1..T+2.
- Multiply 15×15: accept at T → out_valid at T+5, out_result=8'hE1 (225); busy high T+1..T+5.
- Multiply 0×13 and 13×1: results 8'h00 and 8'h0D; 6×7 = 8'h2A.
- Back-pressure: out_ready low for 3 cycles after out_valid → result/out_op constant, in_valid pulses with new operands ignored; out_ready high → IDLE next edge, in_ready=1.
- rst asserted at T+2 of a multiply → next edge: IDLE, out_valid=0, out_result=0; a following 3×5 returns 8'h0F.
- Back-to-back: add 7+9 then multiply 5×3 with in_valid held high → results 8'h10 then 8'h0F, second accept no earlier than the cycle after the first output handshake.

Source files
------------

// File: rtl/adder_mul_sequencer_pkg.sv
// adder_mul_sequencer_pkg: shared states, op codes and sizing helper for the add/multiply sequencer
package adder_mul_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/adder_mul_sequencer_adder.sv
// ripple_adder_w: WIDTH-bit combinational ripple-carry adder with carry-out
module ripple_adder_w #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  logic [WIDTH:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]    = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign cout_o = c[WIDTH];
endmodule

// File: rtl/adder_mul_sequencer.sv
// adder_mul_sequencer: schedules one shared ripple adder for single-pass add or WIDTH-step shift-add multiply
module adder_mul_sequencer
  import adder_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_op,
  output logic               busy
);
  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  state_e             state_q, state_d;
  logic               op_q, op_d, out_op_q, out_op_d;
  logic [WIDTH-1:0]   a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0]   add_b, sum;
  logic               cout;
  logic [WIDTH:0]     step;
  // Add uses a+lo; multiply accumulates into hi, so only the adder's second operand is muxed
  assign add_b = (op_q == OP_MUL) ? hi_q : lo_q;
  ripple_adder_w #(.WIDTH(WIDTH)) u_add (
    .a_i   (a_q),
    .b_i   (add_b),
    .sum_o (sum),
    .cout_o(cout)
  );
  assign step       = lo_q[0] ? {cout, sum} : {1'b0, hi_q};
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = res_q;
  assign out_op     = out_op_q;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    out_op_d = out_op_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        op_d    = in_op;
        a_d     = in_a;
        hi_d    = '0;
        lo_d    = in_b;
        cnt_d   = '0;
        state_d = EXEC;
      end
      EXEC: if (op_q == OP_ADD) begin
        res_d    = {{(WIDTH-1){1'b0}}, cout, sum};
        out_op_d = op_q;
        state_d  = DONE;
      end else begin
        {hi_d, lo_d} = {step, lo_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d    = {step, lo_q[WIDTH-1:1]};
          out_op_d = op_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      out_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      out_op_q <= out_op_d;
    end
  end
endmodule

// File: tb/tb_adder_mul_sequencer.sv
// tb_adder_mul_sequencer: directed and random add/multiply transactions against an arithmetic reference
module tb_adder_mul_sequencer;
  localparam int W = 4;
  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, in_op;
  logic [W-1:0]   in_a, in_b;
  logic           out_valid, out_ready, out_op, busy;
  logic [2*W-1:0] out_result;
  int n_chk = 0;
  int n_err = 0;
  adder_mul_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_op    (out_op),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Issue one operation from a negedge; stall holds out_ready low while junk requests are offered
  task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    int k;
    int exp;
    exp = op ? int'(a) * int'(b) : int'(a) + int'(b);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 50) begin
      chk("busy_exec", int'(busy), 1);
      chk("in_ready_exec", int'(in_ready), 0);
      @(negedge clk);
      k++;
    end
    chk("latency", k, op ? W + 1 : 2);
    chk("result", int'(out_result), exp);
    chk("out_op", int'(out_op), int'(op));
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_op = 1'($urandom);
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_result", int'(out_result), exp);
      chk("hold_op", int'(out_op), int'(op));
      chk("hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", int'(out_valid), 0);
    chk("post_in_ready", int'(in_ready), 1);
    chk("post_busy", int'(busy), 0);
  endtask
  initial begin
    int k;
    rst = 1'b1;
    in_valid = 1'b0;
    in_op = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_result", int'(out_result), 0);
    chk("rst_op", int'(out_op), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    do_op(1'b0, 4'd9, 4'd8, 0);
    do_op(1'b1, 4'd15, 4'd15, 0);
    do_op(1'b1, 4'd0, 4'd13, 0);
    do_op(1'b1, 4'd13, 4'd1, 0);
    do_op(1'b1, 4'd6, 4'd7, 0);
    do_op(1'b0, 4'd15, 4'd15, 3);
    do_op(1'b1, 4'd11, 4'd9, 3);
    // Reset two edges into a multiply discards the partial product
    in_valid = 1'b1;
    in_op = 1'b1;
    in_a = 4'd15;
    in_b = 4'd15;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_result", int'(out_result), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    do_op(1'b1, 4'd3, 4'd5, 0);
    // Back-to-back with in_valid held high and out_ready high
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_op = 1'b0;
    in_a = 4'd7;
    in_b = 4'd9;
    @(posedge clk);
    @(negedge clk);
    in_op = 1'b1;
    in_a = 4'd5;
    in_b = 4'd3;
    k = 1;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_lat_add", k, 2);
    chk("b2b_add", int'(out_result), 16);
    @(negedge clk);
    chk("b2b_idle_gap", int'(busy), 0);
    chk("b2b_gap_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_lat_mul", k, W + 1);
    chk("b2b_mul", int'(out_result), 15);
    chk("b2b_mul_op", int'(out_op), 1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_done", int'(out_valid), 0);
    for (int i = 0; i < 40; i++)
      do_op(1'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
